// File: rtl/ascii_uart_tx_pkg.sv
// ascii_uart_tx_pkg: shared FSM encoding and frame constants for the ASCII UART transmitter.
package ascii_uart_tx_pkg;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int DATA_BITS = 8;
endpackage

// File: rtl/ascii_uart_tx_char_fifo.sv
// char_fifo: synchronous FIFO with push/pop/full/empty/count; push while full is ignored even alongside a pop.
module char_fifo
    import ascii_uart_tx_pkg::*;
#(
    parameter int WIDTH = DATA_BITS,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [4:0]       count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign full    = count == 5'(DEPTH);
    assign empty   = count == 5'd0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];
    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp      <= wp + AW'(1);
            end
            if (do_pop) rp <= rp + AW'(1);
            count <= count + 5'(do_push) - 5'(do_pop);
        end
    end
endmodule

// File: rtl/ascii_uart_tx.sv
// ascii_uart_tx: buffered 8N1 UART transmitter for the character sequencer stream.
// Define ASCII_UART_TX_PARITY_EN to add an even-parity bit (11-bit frame).
module ascii_uart_tx
    import ascii_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       tx,
    output logic       busy,
    output logic [4:0] fifo_count
);
`ifdef ASCII_UART_TX_PARITY_EN
    localparam state_t AFTER_DATA = S_PARITY;
`else
    localparam state_t AFTER_DATA = S_STOP;
`endif
    state_t state, state_d;
    logic [7:0] cnt, cnt_d;
    logic [2:0] idx, idx_d;
    logic [DATA_BITS-1:0] data, head;
    logic tx_d, pop, last, full, empty;

    char_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(char_valid), .pop(pop), .din(char_in),
        .dout(head), .full(full), .empty(empty), .count(fifo_count)
    );

    assign char_ready = !full;
    assign busy       = (state != S_IDLE) || (fifo_count != 5'd0);
    assign last       = cnt == 8'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            tx    <= UART_IDLE_LEVEL;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            tx    <= tx_d;
            if (pop) data <= head;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   state_d = empty ? S_IDLE : S_START;
            S_START:  state_d = last ? S_DATA : S_START;
            S_DATA:   state_d = (last && idx == 3'(DATA_BITS - 1)) ? AFTER_DATA : S_DATA;
`ifdef ASCII_UART_TX_PARITY_EN
            S_PARITY: state_d = last ? S_STOP : S_PARITY;
`endif
            S_STOP:   state_d = last ? S_IDLE : S_STOP;
            default:  state_d = S_IDLE;
        endcase
    end

    // tx is computed from the upcoming state so the registered pin lines up with the state
    always_comb begin
        pop   = (state == S_IDLE) && !empty;
        cnt_d = (state_d != state || last) ? 8'd0 : cnt + 8'd1;
        idx_d = (state == S_DATA && last) ? idx + 3'd1 : idx;
`ifdef ASCII_UART_TX_PARITY_EN
        tx_d  = state_d == S_START  ? 1'b0 :
                state_d == S_DATA   ? data[idx_d] :
                state_d == S_PARITY ? ^data : UART_IDLE_LEVEL;
`else
        tx_d  = state_d == S_START ? 1'b0 :
                state_d == S_DATA  ? data[idx_d] : UART_IDLE_LEVEL;
`endif
    end
endmodule
